clk_drift_ctrl: RTL and testbench

Drift controller for the AEC I2S path: tracks the word-count difference between the master bit clock and the locally generated bit clock, then drives the speed-up and slow-down interrupts to the M4 through the FB message lines. It sits in the IP block in the local bit-clock domain, between the word-tick generators and FB_msg_out. A hysteresis/holdoff state machine keeps firmware from being flooded while the local clock trim settles.

---
 rtl/clk_drift_pkg.sv | 26 ++
 rtl/clk_drift_if.sv | 60 ++++++
 rtl/drift_sat_counter.sv | 49 ++++
 rtl/clk_drift_ctrl.sv | 151 +++++++++++++++
 tb/tb_clk_drift_ctrl.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/clk_drift_pkg.sv
// clk_drift_pkg
//   Shared types and constants for the AEC I2S clock-drift controller.
//   - state_e        : controller FSM state, 3-bit encoding
//   - sat_limit()    : largest positive magnitude a DIFF_W-bit signed drift
//                      counter may hold (symmetric saturation, so the most
//                      negative two's-complement code is never used)
//   - DEF_THRESH / DEF_HYST / DEF_HOLDOFF : default tuning constants
package clk_drift_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_TRACK    = 3'd1,
        ST_SPEEDUP  = 3'd2,
        ST_SLOWDOWN = 3'd3,
        ST_HOLDOFF  = 3'd4
    } state_e;

    localparam int DEF_THRESH  = 4;
    localparam int DEF_HYST    = 1;
    localparam int DEF_HOLDOFF = 16;

    function automatic int sat_limit(input int diff_w);
        return (1 << (diff_w - 1)) - 1;
    endfunction

endpackage

// File: rtl/clk_drift_if.sv
// clk_drift_if
//   Signal bundle between the word-tick generators / FB message logic and
//   clk_drift_ctrl. Clock and reset are not part of the bundle.
//   Signals:
//     enable_i              tracking enable (level)
//     master_word_tick_i    one-cycle pulse per master word
//     local_word_tick_i     one-cycle pulse per local word
//     Interrupt_speedup_o   local clock behind master
//     Interrupt_slowdown_o  local clock ahead of master
//     drift_o               signed drift, master minus local (registered)
//     fsm_state_o           current controller state (debug visibility)
//     master_wordcnt_is_ahead_o / local_wordcnt_is_ahead_o
//                           sign flags of drift_o, only with CLK_DRIFT_DBG_EN
//   Modports: slave = the controller, master = the side driving the ticks.
//   Handshake: there is no valid/ready pair here; ticks are single-cycle
//   strobes sampled on every rising clock edge and need no acknowledgement.
interface clk_drift_if #(
    parameter int DIFF_W = 8
);
    logic                         enable_i;
    logic                         master_word_tick_i;
    logic                         local_word_tick_i;
    logic                         Interrupt_speedup_o;
    logic                         Interrupt_slowdown_o;
    logic signed [DIFF_W-1:0]     drift_o;
    clk_drift_pkg::state_e        fsm_state_o;
`ifdef CLK_DRIFT_DBG_EN
    logic                         master_wordcnt_is_ahead_o;
    logic                         local_wordcnt_is_ahead_o;
`endif

    modport slave (
        input  enable_i,
        input  master_word_tick_i,
        input  local_word_tick_i,
        output Interrupt_speedup_o,
        output Interrupt_slowdown_o,
        output drift_o,
`ifdef CLK_DRIFT_DBG_EN
        output master_wordcnt_is_ahead_o,
        output local_wordcnt_is_ahead_o,
`endif
        output fsm_state_o
    );

    modport master (
        output enable_i,
        output master_word_tick_i,
        output local_word_tick_i,
        input  Interrupt_speedup_o,
        input  Interrupt_slowdown_o,
        input  drift_o,
`ifdef CLK_DRIFT_DBG_EN
        input  master_wordcnt_is_ahead_o,
        input  local_wordcnt_is_ahead_o,
`endif
        input  fsm_state_o
    );

endinterface

// File: rtl/drift_sat_counter.sv
// drift_sat_counter
//   Saturating signed up/down counter with synchronous clear.
//   Ports:
//     clk, rst_n     clock, asynchronous active-low reset
//     clr_i          synchronous clear to 0 (wins over inc/dec)
//     inc_i, dec_i   +1 / -1 requests; both or neither hold the value
//     count_o        registered count
//     count_next_o   value the count takes at the next edge
//   Range is +/-sat_limit(W); the counter never wraps.
module drift_sat_counter
    import clk_drift_pkg::*;
#(
    parameter int W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clr_i,
    input  logic                inc_i,
    input  logic                dec_i,
    output logic signed [W-1:0] count_o,
    output logic signed [W-1:0] count_next_o
);

    localparam logic signed [W-1:0] MAX_V = W'(sat_limit(W));
    localparam logic signed [W-1:0] MIN_V = W'(-sat_limit(W));

    logic signed [W-1:0] count_q;
    logic signed [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i && !dec_i) begin
            if (count_q != MAX_V) count_d = count_q + W'(1);
        end else if (dec_i && !inc_i) begin
            if (count_q != MIN_V) count_d = count_q - W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) count_q <= '0;
        else        count_q <= count_d;
    end

    assign count_o      = count_q;
    assign count_next_o = count_d;

endmodule

// File: rtl/clk_drift_ctrl.sv
// clk_drift_ctrl
//   Drift controller for the AEC I2S path. Counts master words minus local
//   words and raises speed-up / slow-down interrupts with hysteresis and a
//   post-release holdoff so firmware is not flooded while the trim settles.
//   Ports:
//     CLK_IP_i     local bit clock (single domain)
//     RST_IP_n_i   asynchronous active-low reset (deassertion synchronised
//                  outside this block)
//     bus          clk_drift_if.slave: enable, word ticks, interrupts,
//                  drift value, FSM state, optional debug sign flags
//   Optional feature: define CLK_DRIFT_DBG_EN to add the registered
//   master/local "is ahead" flags; without it they do not exist.
//   Latency: tick in cycle c -> drift_o at c+1 -> interrupt at c+2, because
//   the FSM decides on the registered drift and the interrupts are decoded
//   from the registered state.
module clk_drift_ctrl
    import clk_drift_pkg::*;
#(
    parameter int DIFF_W  = 8,
    parameter int THRESH  = DEF_THRESH,
    parameter int HYST    = DEF_HYST,
    parameter int HOLDOFF = DEF_HOLDOFF
) (
    input  logic       CLK_IP_i,
    input  logic       RST_IP_n_i,
    clk_drift_if.slave bus
);

    localparam int HO_W = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

    localparam logic signed [DIFF_W-1:0] THRESH_S     = DIFF_W'(THRESH);
    localparam logic signed [DIFF_W-1:0] NEG_THRESH_S = DIFF_W'(-THRESH);
    localparam logic signed [DIFF_W-1:0] HYST_S       = DIFF_W'(HYST);
    localparam logic signed [DIFF_W-1:0] NEG_HYST_S   = DIFF_W'(-HYST);
    localparam logic [HO_W-1:0]          HOLD_LOAD    = HO_W'(HOLDOFF - 1);

    state_e                   state_q;
    state_e                   state_d;
    logic [HO_W-1:0]          hold_cnt_q;
    logic [HO_W-1:0]          hold_cnt_d;
    logic                     drift_clr;
    logic signed [DIFF_W-1:0] drift_q;
    logic signed [DIFF_W-1:0] drift_nxt;

    // Clearing on !enable_i as well as in IDLE makes drift_o read 0 in the
    // very first cycle after enable drops, together with the IDLE state.
    assign drift_clr = !bus.enable_i || (state_q == ST_IDLE);

    drift_sat_counter #(
        .W (DIFF_W)
    ) u_drift_cnt (
        .clk          (CLK_IP_i),
        .rst_n        (RST_IP_n_i),
        .clr_i        (drift_clr),
        .inc_i        (bus.master_word_tick_i),
        .dec_i        (bus.local_word_tick_i),
        .count_o      (drift_q),
        .count_next_o (drift_nxt)
    );

    // Next-state logic. Disable has top priority. Release from either
    // interrupt state always goes through HOLDOFF, even on overshoot, and
    // thresholds are not evaluated while in HOLDOFF.
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        if (!bus.enable_i) begin
            state_d    = ST_IDLE;
            hold_cnt_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_TRACK;
                end
                ST_TRACK: begin
                    if (drift_q >= THRESH_S)          state_d = ST_SPEEDUP;
                    else if (drift_q <= NEG_THRESH_S) state_d = ST_SLOWDOWN;
                end
                ST_SPEEDUP: begin
                    if (drift_q <= HYST_S) begin
                        state_d    = ST_HOLDOFF;
                        hold_cnt_d = HOLD_LOAD;
                    end
                end
                ST_SLOWDOWN: begin
                    if (drift_q >= NEG_HYST_S) begin
                        state_d    = ST_HOLDOFF;
                        hold_cnt_d = HOLD_LOAD;
                    end
                end
                ST_HOLDOFF: begin
                    // Loaded with HOLDOFF-1 on entry, so the state lasts
                    // exactly HOLDOFF cycles including the one with count 0.
                    if (hold_cnt_q == '0) state_d    = ST_TRACK;
                    else                  hold_cnt_d = hold_cnt_q - HO_W'(1);
                end
                default: begin
                    state_d    = ST_IDLE;
                    hold_cnt_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge CLK_IP_i or negedge RST_IP_n_i) begin
        if (!RST_IP_n_i) begin
            state_q    <= ST_IDLE;
            hold_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

    assign bus.Interrupt_speedup_o  = (state_q == ST_SPEEDUP);
    assign bus.Interrupt_slowdown_o = (state_q == ST_SLOWDOWN);
    assign bus.drift_o              = drift_q;
    assign bus.fsm_state_o          = state_q;

`ifdef CLK_DRIFT_DBG_EN
    // Flags are derived from the counter's next value so they change on the
    // same edge as drift_o and always agree with its sign.
    logic master_ahead_q;
    logic master_ahead_d;
    logic local_ahead_q;
    logic local_ahead_d;

    always_comb begin
        master_ahead_d = (drift_nxt > 0);
        local_ahead_d  = (drift_nxt < 0);
    end

    always_ff @(posedge CLK_IP_i or negedge RST_IP_n_i) begin
        if (!RST_IP_n_i) begin
            master_ahead_q <= 1'b0;
            local_ahead_q  <= 1'b0;
        end else begin
            master_ahead_q <= master_ahead_d;
            local_ahead_q  <= local_ahead_d;
        end
    end

    assign bus.master_wordcnt_is_ahead_o = master_ahead_q;
    assign bus.local_wordcnt_is_ahead_o  = local_ahead_q;
`else
    // drift_nxt only feeds the debug flags.
    logic unused_drift_nxt;
    assign unused_drift_nxt = ^drift_nxt;
`endif

endmodule

// File: tb/tb_clk_drift_ctrl.sv
// tb_clk_drift_ctrl
//   Directed bench for clk_drift_ctrl with DIFF_W=8, THRESH=4, HYST=1,
//   HOLDOFF=16. Inputs change 1 ns after the rising edge; outputs are
//   examined at the same point, i.e. after the edge has settled.
module tb_clk_drift_ctrl;
    import clk_drift_pkg::*;

    localparam int DIFF_W = 8;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    clk_drift_if #(.DIFF_W(DIFF_W)) bus ();

    clk_drift_ctrl #(
        .DIFF_W  (DIFF_W),
        .THRESH  (4),
        .HYST    (1),
        .HOLDOFF (16)
    ) dut (
        .CLK_IP_i   (clk),
        .RST_IP_n_i (rst_n),
        .bus        (bus.slave)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic signed [31:0] got,
                            input logic signed [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic m, input logic l);
        bus.master_word_tick_i = m;
        bus.local_word_tick_i  = l;
        step();
        bus.master_word_tick_i = 1'b0;
        bus.local_word_tick_i  = 1'b0;
    endtask

    task automatic check_outs(input string tag, input int drift, input int su,
                              input int sd, input state_e st);
        check_eq({tag, "_drift"},    int'(bus.drift_o), drift);
        check_eq({tag, "_speedup"},  {31'd0, bus.Interrupt_speedup_o}, su);
        check_eq({tag, "_slowdown"}, {31'd0, bus.Interrupt_slowdown_o}, sd);
        check_eq({tag, "_state"},    int'(bus.fsm_state_o), int'(st));
    endtask

`ifdef CLK_DRIFT_DBG_EN
    always @(negedge clk) begin
        if (rst_n) begin
            check_eq("dbg_master_ahead", {31'd0, bus.master_wordcnt_is_ahead_o},
                     {31'd0, (bus.drift_o > 0)});
            check_eq("dbg_local_ahead", {31'd0, bus.local_wordcnt_is_ahead_o},
                     {31'd0, (bus.drift_o < 0)});
        end
    end
`endif

    int exp_drift;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        bus.enable_i           = 1'b0;
        bus.master_word_tick_i = 1'b0;
        bus.local_word_tick_i  = 1'b0;

        // reset state
        #3;
        check_outs("reset", 0, 0, 0, ST_IDLE);
        #4 rst_n = 1'b1;
        step();
        check_outs("idle_disabled", 0, 0, 0, ST_IDLE);
        bus.enable_i = 1'b1;
        step();
        check_outs("enter_track", 0, 0, 0, ST_TRACK);

        // matched ticks every 32 cycles for 1000 cycles
        for (int i = 0; i < 1000; i++) begin
            pulse((i % 32) == 0, (i % 32) == 0);
            check_eq("matched_drift", int'(bus.drift_o), 0);
            check_eq("matched_intr", {30'd0, bus.Interrupt_speedup_o,
                     bus.Interrupt_slowdown_o}, 0);
        end

        // speed-up: 4 master ticks, interrupt 2 cycles after the 4th
        for (int i = 0; i < 3; i++) pulse(1'b1, 1'b0);
        check_outs("su_three", 3, 0, 0, ST_TRACK);
        pulse(1'b1, 1'b0);
        check_outs("su_c1", 4, 0, 0, ST_TRACK);
        step();
        check_outs("su_c2", 4, 1, 0, ST_SPEEDUP);
        // 3 local ticks back to drift 1, release 2 cycles after the 3rd
        pulse(1'b0, 1'b1);
        pulse(1'b0, 1'b1);
        pulse(1'b0, 1'b1);
        check_outs("su_rel_c1", 1, 1, 0, ST_SPEEDUP);
        step();
        check_outs("su_rel_c2", 1, 0, 0, ST_HOLDOFF);
        for (int i = 0; i < 15; i++) begin
            step();
            check_eq("su_holdoff_state", int'(bus.fsm_state_o), int'(ST_HOLDOFF));
        end
        step();
        check_outs("su_back_track", 1, 0, 0, ST_TRACK);

        // slow-down mirror: 5 local ticks from drift 1 to -4
        for (int i = 0; i < 4; i++) pulse(1'b0, 1'b1);
        check_outs("sd_minus3", -3, 0, 0, ST_TRACK);
        pulse(1'b0, 1'b1);
        check_outs("sd_c1", -4, 0, 0, ST_TRACK);
        step();
        check_outs("sd_c2", -4, 0, 1, ST_SLOWDOWN);
        pulse(1'b1, 1'b0);
        pulse(1'b1, 1'b0);
        pulse(1'b1, 1'b0);
        check_outs("sd_rel_c1", -1, 0, 1, ST_SLOWDOWN);
        step();
        check_outs("sd_rel_c2", -1, 0, 0, ST_HOLDOFF);
        for (int i = 0; i < 15; i++) begin
            step();
            check_eq("sd_holdoff_state", int'(bus.fsm_state_o), int'(ST_HOLDOFF));
        end
        step();
        check_outs("sd_back_track", -1, 0, 0, ST_TRACK);

        // simultaneous ticks every cycle hold the drift
        for (int i = 0; i < 20; i++) pulse(1'b1, 1'b1);
        check_outs("both_ticks", -1, 0, 0, ST_TRACK);

        // 200 master-only ticks: saturate at +127, no wrap
        exp_drift = -1;
        for (int i = 0; i < 200; i++) begin
            pulse(1'b1, 1'b0);
            exp_drift = (exp_drift < 127) ? exp_drift + 1 : 127;
            check_eq("sat_drift", int'(bus.drift_o), exp_drift);
        end
        check_outs("sat_final", 127, 1, 0, ST_SPEEDUP);

        // disable while in SPEEDUP: everything back to 0 next cycle
        bus.enable_i = 1'b0;
        step();
        check_outs("disable_su", 0, 0, 0, ST_IDLE);
        bus.enable_i = 1'b1;
        step();
        check_outs("reenable", 0, 0, 0, ST_TRACK);

        // drift reaches -5 inside HOLDOFF: slow-down waits for TRACK
        for (int i = 0; i < 4; i++) pulse(1'b1, 1'b0);
        step();
        check_outs("ho_su", 4, 1, 0, ST_SPEEDUP);
        for (int i = 0; i < 3; i++) pulse(1'b0, 1'b1);
        check_outs("ho_pre", 1, 1, 0, ST_SPEEDUP);
        // 4th tick cycle still SPEEDUP; ticks 5..9 land in HOLDOFF cycles 1..5
        for (int i = 0; i < 6; i++) pulse(1'b0, 1'b1);
        check_outs("ho_minus5", -5, 0, 0, ST_HOLDOFF);
        for (int i = 0; i < 10; i++) begin
            step();
            check_eq("ho_no_intr", {31'd0, bus.Interrupt_slowdown_o}, 0);
            check_eq("ho_hold_state", int'(bus.fsm_state_o), int'(ST_HOLDOFF));
        end
        step();
        check_outs("ho_track", -5, 0, 0, ST_TRACK);
        step();
        check_outs("ho_slowdown", -5, 0, 1, ST_SLOWDOWN);

        // asynchronous reset mid-SLOWDOWN, no clock edge in between
        #2 rst_n = 1'b0;
        #1;
        check_outs("async_rst", 0, 0, 0, ST_IDLE);
`ifdef CLK_DRIFT_DBG_EN
        check_eq("async_rst_master_ahead", {31'd0, bus.master_wordcnt_is_ahead_o}, 0);
        check_eq("async_rst_local_ahead", {31'd0, bus.local_wordcnt_is_ahead_o}, 0);
`endif
        #3 rst_n = 1'b1;
        step();
        check_outs("after_rst", 0, 0, 0, ST_TRACK);

        // final report
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
